regfile_sb: RTL and testbench

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_clr_seq.sv | 59 +++++
 rtl/regfile_sb.sv | 80 ++++++++
 tb/tb_regfile_sb.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and clear-FSM state type for the scoreboarded register file
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/regfile_clr_seq.sv
// rtl/regfile_clr_seq.sv - bulk-clear sequencer: walks idx 1..NREG-1, one register per cycle
module regfile_clr_seq
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  localparam int AW = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          ready,
  output logic          clr_active,
  output logic [AW-1:0] clr_idx
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= AW'(1);
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = AW'(1);
        end
      end
      CLEAR: begin
        // Register 0 is hardwired, so the sweep wraps back to 1, not 0.
        if (idx_q == AW'(NREG - 1)) begin
          state_d = IDLE;
          idx_d   = AW'(1);
        end else begin
          idx_d = idx_q + AW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = AW'(1);
      end
    endcase
  end

  assign ready      = (state_q == IDLE);
  assign clr_active = (state_q == CLEAR);
  assign clr_idx    = idx_q;

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with busy scoreboard, write-first bypass and bulk clear
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int NRD  = NRD_DEF,
  localparam int AW = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rs,
  output logic [NRD*XLEN-1:0] rdata,
  output logic [NRD-1:0]      rbusy,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                rsv_en,
  input  logic [AW-1:0]       rsv_addr,
  input  logic                clr_req,
  output logic                ready
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic            clr_active;
  logic [AW-1:0]   clr_idx;

  regfile_clr_seq #(.NREG(NREG)) u_clr_seq (
    .clk        (clk),
    .rst        (rst),
    .clr_req    (clr_req),
    .ready      (ready),
    .clr_active (clr_active),
    .clr_idx    (clr_idx)
  );

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (clr_active) begin
      regs_d[clr_idx] = '0;
      busy_d[clr_idx] = 1'b0;
    end else if (ready) begin
      if (wr_en) begin
        regs_d[wr_addr] = wr_data;
        busy_d[wr_addr] = 1'b0;
      end
      // Reserve applied after the write so a same-address pair leaves busy set.
      if (rsv_en) begin
        busy_d[rsv_addr] = 1'b1;
      end
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] addr;
    logic          hit;
    assign addr = rs[k*AW +: AW];
    assign hit  = ready && wr_en && (wr_addr == addr) && (addr != '0);
    assign rdata[k*XLEN +: XLEN] = hit ? wr_data : regs_q[addr];
    assign rbusy[k] = busy_q[addr] & ~hit;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed vector bench for regfile_sb (XLEN=32, NREG=32, NRD=2)
module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NRD*AW-1:0]   rs = '0;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic [XLEN-1:0]     wr_data = '0;
  logic                rsv_en = 1'b0;
  logic [AW-1:0]       rsv_addr = '0;
  logic                clr_req = 1'b0;
  logic                ready;

  int n_tests = 0;
  int n_fail  = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk      (clk),
    .rst      (rst),
    .rs       (rs),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .clr_req  (clr_req),
    .ready    (ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        re;
    logic [4:0]  ra;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
  } vec_t;

  vec_t vecs [19];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    wr_en   = 1'b0;
    rsv_en  = 1'b0;
    clr_req = 1'b0;
  endtask

  initial begin
    int cnt;
    vecs[0]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd0, 32'h0,        32'h0,        2'b00};
    vecs[1]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd3, 5'd0, 32'h0,        32'h0,        2'b00};
    vecs[2]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF, 2'b00};
    vecs[3]  = '{1'b1, 5'd0, 32'h1234,     1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 2'b00};
    vecs[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        2'b00};
    vecs[5]  = '{1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd7, 5'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 2'b00};
    vecs[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 5'd9, 5'd7, 32'h0,        32'hA5A5A5A5, 2'b00};
    vecs[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h0,        32'h0,        2'b11};
    vecs[8]  = '{1'b1, 5'd9, 32'h11112222, 1'b1, 5'd9, 5'd9, 5'd3, 32'h11112222, 32'h0,        2'b00};
    vecs[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h11112222, 32'h11112222, 2'b11};
    vecs[10] = '{1'b1, 5'd9, 32'h33334444, 1'b0, 5'd0, 5'd1, 5'd9, 32'h0,        32'h33334444, 2'b00};
    vecs[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd9, 5'd9, 32'h33334444, 32'h33334444, 2'b00};
    vecs[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 5'd9, 32'h0,        32'h33334444, 2'b00};
    vecs[13] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 5'd9, 32'h0,        32'h33334444, 2'b00};
    vecs[14] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd0, 32'h0,        32'h0,        2'b00};
    vecs[15] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3, 5'd3, 5'd0, 32'h0,        32'h0,        2'b01};
    vecs[16] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h0,        32'h0,        2'b11};
    vecs[17] = '{1'b1, 5'd3, 32'h5,        1'b0, 5'd0, 5'd3, 5'd3, 32'h5,        32'h5,        2'b00};
    vecs[18] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd3, 5'd3, 32'h5,        32'h5,        2'b00};

    #1;
    rs = {5'd4, 5'd7};
    #1;
    check("reset_ready", {31'b0, ready}, 32'h1);
    check("reset_rdata0", rdata[31:0], 32'h0);
    check("reset_rbusy", {30'b0, rbusy}, 32'h0);
    #10;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      wr_en    = vecs[i].we;
      wr_addr  = vecs[i].wa;
      wr_data  = vecs[i].wd;
      rsv_en   = vecs[i].re;
      rsv_addr = vecs[i].ra;
      rs       = {vecs[i].r1, vecs[i].r0};
      #1;
      check($sformatf("vec%0d_rdata0", i), rdata[31:0], vecs[i].e0);
      check($sformatf("vec%0d_rdata1", i), rdata[63:32], vecs[i].e1);
      check($sformatf("vec%0d_rbusy", i), {30'b0, rbusy}, {30'b0, vecs[i].eb});
      check($sformatf("vec%0d_ready", i), {31'b0, ready}, 32'h1);
    end

    // Fill r1..r31 with data and leave every one reserved.
    for (int r = 1; r < NREG; r++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(r); wr_data = 32'h1000_0000 + r;
      rsv_en = 1'b1; rsv_addr = AW'(r);
    end
    @(negedge clk);
    drive_idle();
    clr_req = 1'b1;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'hFFFF_FFFF;
    rsv_en = 1'b1; rsv_addr = 5'd31; rs = {5'd1, 5'd31};
    #1;
    check("clr_no_bypass", rdata[31:0], 32'h1000_001F);
    check("clr_busy31", {31'b0, rbusy[0]}, 32'h1);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      if (ready) break;
      cnt++;
      @(negedge clk);
      #1;
    end
    drive_idle();
    check("clr_cycles", cnt, 32'd31);
    for (int r = 0; r < NREG; r++) begin
      @(negedge clk);
      rs = {AW'(NREG - 1 - r), AW'(r)};
      #1;
      check($sformatf("post_clr_r%0d", r), rdata[31:0], 32'h0);
      check($sformatf("post_clr_busy_r%0d", r), {30'b0, rbusy}, 32'h0);
    end

    // Reset in the middle of a sweep.
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h20;
    rsv_en = 1'b1; rsv_addr = 5'd20;
    @(negedge clk);
    drive_idle();
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    rs = {5'd20, 5'd20};
    repeat (9) @(negedge clk);
    #1;
    check("mid_clr_ready", {31'b0, ready}, 32'h0);
    check("mid_clr_r20", rdata[31:0], 32'h20);
    check("mid_clr_busy20", {30'b0, rbusy}, 32'h3);
    #1;
    rst = 1'b0;
    #1;
    check("rst_abort_r20", rdata[31:0], 32'h0);
    check("rst_abort_busy", {30'b0, rbusy}, 32'h0);
    check("rst_abort_ready", {31'b0, ready}, 32'h1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hCAFE_0006;
    @(negedge clk);
    drive_idle();
    rs = {5'd20, 5'd6};
    #1;
    check("post_rst_ready", {31'b0, ready}, 32'h1);
    check("post_rst_r6", rdata[31:0], 32'hCAFE_0006);
    check("post_rst_r20", rdata[63:32], 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
